button_bank: RTL and testbench

Parametrised multi-channel push-button front end: each of `N_CH` asynchronous button inputs is synchronised and debounced, and then classified into rise, fall, long-press and auto-repeat events. Channels are fully independent per-channel instances of `button_channel` behind a common register-level interface. The block sits between board pins and control FSMs such as menus and counters.

---
 rtl/button_pkg.sv | 27 ++
 rtl/button_bank_if.sv | 27 ++
 rtl/button_channel.sv | 159 +++++++++++++++
 rtl/button_bank.sv | 67 ++++++
 tb/tb_button_bank.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end.
//   hold_state_e : per-channel hold classifier states
//   max3         : largest of three cycle counts
//   cnt_fits     : true when a counter of the given width can hold a value
package button_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2,
        REPEAT  = 2'd3
    } hold_state_e;

    function automatic longint unsigned max3(input longint unsigned a,
                                             input longint unsigned b,
                                             input longint unsigned c);
        longint unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A width-w counter holds 0 .. 2**w-1, so val fits when clog2(val+1) <= w.
    function automatic bit cnt_fits(input longint unsigned val, input int unsigned width);
        return ($clog2(val + 64'd1) <= width);
    endfunction

endpackage

// File: rtl/button_bank_if.sv
// Pin-side and event-side signals of the button bank, one bit per channel.
//   noisy, repeat_en            : driven by the board / host (master)
//   debounced, p_edge, n_edge,
//   any_edge, long_press,
//   repeat_pulse                : driven by button_bank (slave)
interface button_bank_if #(
    parameter int unsigned N_CH = 4
);
    logic [N_CH-1:0] noisy;
    logic [N_CH-1:0] repeat_en;
    logic [N_CH-1:0] debounced;
    logic [N_CH-1:0] p_edge;
    logic [N_CH-1:0] n_edge;
    logic [N_CH-1:0] any_edge;
    logic [N_CH-1:0] long_press;
    logic [N_CH-1:0] repeat_pulse;

    modport master (
        output noisy, repeat_en,
        input  debounced, p_edge, n_edge, any_edge, long_press, repeat_pulse
    );

    modport slave (
        input  noisy, repeat_en,
        output debounced, p_edge, n_edge, any_edge, long_press, repeat_pulse
    );
endinterface

// File: rtl/button_channel.sv
// One push-button channel: synchroniser, debounce filter, registered edge
// pulses and the hold classifier (long press / auto-repeat).
//   clk, rst      : clock, synchronous active-high reset
//   noisy         : raw asynchronous button level
//   repeat_en     : auto-repeat enable, sampled every cycle
//   debounced     : filtered level
//   p_edge/n_edge : 1-cycle pulses in the first cycle debounced shows its new value
//   long_press    : 1-cycle pulse when a hold reaches LONG_CYC
//   repeat_pulse  : 1-cycle pulses every REPEAT_CYC while held and enabled
//
// Hold FSM:
//   state   | meaning
//   IDLE    | button released, waiting for a debounced rise
//   PRESSED | held, counting towards LONG_CYC
//   LONG    | long press reported, repeat disabled (or hop pending)
//   REPEAT  | auto-repeating, counting towards REPEAT_CYC
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 1000,
    parameter int unsigned LONG_CYC     = 50_000_000,
    parameter int unsigned REPEAT_CYC   = 10_000_000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic noisy,
    input  logic repeat_en,
    output logic debounced,
    output logic p_edge,
    output logic n_edge,
    output logic long_press,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       dcnt_q, dcnt_d;
    logic [CNT_W-1:0]       hcnt_q, hcnt_d;
    logic                   deb_q, deb_d;
    logic                   p_edge_q, p_edge_d;
    logic                   n_edge_q, n_edge_d;
    logic                   long_q, long_d;
    logic                   rep_q, rep_d;
    hold_state_e            state_q, state_d;

    logic synced;
    logic deb_flip;
    logic rise;
    logic fall;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], noisy};
        synced = sync_q[SYNC_STAGES-1];

        // Toggle on the DEBOUNCE_CYC-th consecutive mismatch cycle.
        deb_flip = (synced != deb_q) && (dcnt_q == DEB_TC);
        if ((synced == deb_q) || deb_flip) begin
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + ONE;
        end
        deb_d = deb_q ^ deb_flip;

        // Edges are taken from the toggle condition so the pulses line up with
        // the cycle debounced first shows its new value.
        rise     = deb_flip & ~deb_q;
        fall     = deb_flip &  deb_q;
        p_edge_d = rise;
        n_edge_d = fall;

        state_d = state_q;
        hcnt_d  = hcnt_q;
        long_d  = 1'b0;
        rep_d   = 1'b0;

        // Release overrides everything, including a coincident terminal count.
        if (fall) begin
            state_d = IDLE;
            hcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    hcnt_d = '0;
                    if (rise) begin
                        state_d = PRESSED;
                    end
                end
                PRESSED: begin
                    if (hcnt_q == LONG_TC) begin
                        long_d  = 1'b1;
                        hcnt_d  = '0;
                        state_d = LONG;
                    end else begin
                        hcnt_d = hcnt_q + ONE;
                    end
                end
                LONG: begin
                    hcnt_d = '0;
                    if (repeat_en) begin
                        state_d = REPEAT;
                    end
                end
                REPEAT: begin
                    // A disabled cycle never pulses, even on the terminal count.
                    if (!repeat_en) begin
                        state_d = LONG;
                        hcnt_d  = '0;
                    end else if (hcnt_q == REP_TC) begin
                        rep_d  = 1'b1;
                        hcnt_d = '0;
                    end else begin
                        hcnt_d = hcnt_q + ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            dcnt_q   <= '0;
            hcnt_q   <= '0;
            deb_q    <= 1'b0;
            p_edge_q <= 1'b0;
            n_edge_q <= 1'b0;
            long_q   <= 1'b0;
            rep_q    <= 1'b0;
            state_q  <= IDLE;
        end else begin
            sync_q   <= sync_d;
            dcnt_q   <= dcnt_d;
            hcnt_q   <= hcnt_d;
            deb_q    <= deb_d;
            p_edge_q <= p_edge_d;
            n_edge_q <= n_edge_d;
            long_q   <= long_d;
            rep_q    <= rep_d;
            state_q  <= state_d;
        end
    end

    assign debounced    = deb_q;
    assign p_edge       = p_edge_q;
    assign n_edge       = n_edge_q;
    assign long_press   = long_q;
    assign repeat_pulse = rep_q;

endmodule

// File: rtl/button_bank.sv
// Multi-channel push-button front end: N_CH independent button_channel
// instances behind one button_bank_if.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of button_bank_if (noisy/repeat_en in, events out)
module button_bank
    import button_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 1000,
    parameter int unsigned LONG_CYC     = 50_000_000,
    parameter int unsigned REPEAT_CYC   = 10_000_000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic         clk,
    input  logic         rst,
    button_bank_if.slave bus
);

    localparam longint unsigned MAX_CYC = max3(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC);

    generate
        if (!cnt_fits(MAX_CYC, CNT_W)) begin : g_bad_cnt_w
            $error("button_bank: CNT_W too narrow for the largest cycle count");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("button_bank: SYNC_STAGES must be at least 2");
        end
        if ((N_CH < 1) || (DEBOUNCE_CYC < 1) || (LONG_CYC < 1) || (REPEAT_CYC < 1)) begin : g_bad_param
            $error("button_bank: N_CH and cycle counts must be at least 1");
        end
    endgenerate

    logic [N_CH-1:0] deb_v;
    logic [N_CH-1:0] pe_v;
    logic [N_CH-1:0] ne_v;
    logic [N_CH-1:0] lp_v;
    logic [N_CH-1:0] rp_v;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .REPEAT_CYC   (REPEAT_CYC),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .noisy        (bus.noisy[i]),
            .repeat_en    (bus.repeat_en[i]),
            .debounced    (deb_v[i]),
            .p_edge       (pe_v[i]),
            .n_edge       (ne_v[i]),
            .long_press   (lp_v[i]),
            .repeat_pulse (rp_v[i])
        );
    end

    assign bus.debounced    = deb_v;
    assign bus.p_edge       = pe_v;
    assign bus.n_edge       = ne_v;
    assign bus.any_edge     = pe_v | ne_v;
    assign bus.long_press   = lp_v;
    assign bus.repeat_pulse = rp_v;

endmodule

// File: tb/tb_button_bank.sv
module tb_button_bank;

    localparam int N   = 4;
    localparam int S   = 2;
    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int REP = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    button_bank_if #(.N_CH(N)) bus ();

    button_bank #(
        .N_CH         (N),
        .SYNC_STAGES  (S),
        .DEBOUNCE_CYC (DEB),
        .LONG_CYC     (LNG),
        .REPEAT_CYC   (REP),
        .CNT_W        (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] outs();
        return {bus.debounced, bus.p_edge, bus.n_edge, bus.any_edge, bus.long_press, bus.repeat_pulse};
    endfunction

    // ---------------- behavioural model (event timing per channel) ----------------
    int cyc = 0;
    bit pipe [N][$];     // noisy samples still on their way to the synced point
    bit win  [N][$];     // last DEB synced values
    bit m_deb [N];
    int last_tog [N];    // edge of last debounced change (or reset)
    int d_edge [N];      // edge of the debounced rise of the current hold, -1 none
    int l_edge [N];      // edge of long_press in the current hold, -1 none
    int hop [N];         // edge repeat started counting from, -1 when not repeating
    logic [N-1:0] e_deb = '0, e_p = '0, e_n = '0, e_long = '0, e_rep = '0;

    task automatic model_step();
        bit s_now, all_diff, tog;
        for (int ch = 0; ch < N; ch++) begin
            if (rst) begin
                pipe[ch].delete();
                for (int i = 0; i < S; i++) pipe[ch].push_back(1'b0);
                win[ch].delete();
                m_deb[ch] = 0; last_tog[ch] = cyc;
                d_edge[ch] = -1; l_edge[ch] = -1; hop[ch] = -1;
                e_deb[ch] = 0; e_p[ch] = 0; e_n[ch] = 0; e_long[ch] = 0; e_rep[ch] = 0;
            end else begin
                e_p[ch] = 0; e_n[ch] = 0; e_long[ch] = 0; e_rep[ch] = 0;
                s_now = pipe[ch].pop_front();
                pipe[ch].push_back(bus.noisy[ch]);
                win[ch].push_back(s_now);
                if (win[ch].size() > DEB) void'(win[ch].pop_front());
                all_diff = (win[ch].size() == DEB);
                for (int i = 0; i < win[ch].size(); i++)
                    if (win[ch][i] == m_deb[ch]) all_diff = 0;
                tog = all_diff && ((cyc - last_tog[ch]) >= DEB);
                if (tog) begin
                    m_deb[ch] = ~m_deb[ch];
                    last_tog[ch] = cyc;
                    l_edge[ch] = -1; hop[ch] = -1;
                    if (m_deb[ch]) begin e_p[ch] = 1; d_edge[ch] = cyc; end
                    else begin e_n[ch] = 1; d_edge[ch] = -1; end
                end else if (d_edge[ch] >= 0) begin
                    if (l_edge[ch] < 0) begin
                        if (cyc - d_edge[ch] == LNG) begin e_long[ch] = 1; l_edge[ch] = cyc; end
                    end else if (!bus.repeat_en[ch]) hop[ch] = -1;
                    else if (hop[ch] < 0) hop[ch] = cyc;
                    else if (((cyc - hop[ch]) % REP) == 0) e_rep[ch] = 1;
                end
                e_deb[ch] = m_deb[ch];
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on)
            chk("cycle_outputs", {8'h0, outs()}, {8'h0, e_deb, e_p, e_n, e_p | e_n, e_long, e_rep});
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic acc_b;
    int   lp_cnt, lp_e, ne_e, late, rp_cnt, de_e, pe_cnt;
    int   rq[$];
    int   pct [N];
    logic [N-1:0] nz, re;

    task automatic bounce_hold(input bit v, input int n);
        bus.noisy[1] = v;
        for (int k = 0; k < n; k++) begin
            step(1);
            acc_b = acc_b | bus.debounced[1] | bus.p_edge[1] | bus.n_edge[1];
        end
    endtask

    initial begin
        bus.noisy = '0;
        bus.repeat_en = '0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        chk_on = 1;
        chk("reset_outputs", {8'h0, outs()}, 32'h0);

        // clean press on channel 0
        bus.noisy[0] = 1'b1;
        step(5);
        chk("press_pre", bus.debounced[0], 0);
        step(1);
        chk("press_rise", {bus.debounced[0], bus.p_edge[0], bus.any_edge[0]}, 3'b111);
        chk("press_isolation", {bus.debounced[3:1], bus.p_edge[3:1]}, 0);
        step(1);
        chk("press_pulse_width", {bus.debounced[0], bus.p_edge[0], bus.any_edge[0]}, 3'b100);
        bus.noisy[0] = 1'b0;
        step(10);

        // bounce on channel 1
        acc_b = 1'b0;
        bounce_hold(1, 3); bounce_hold(0, 1); bounce_hold(1, 3); bounce_hold(0, 2);
        chk("bounce_quiet", acc_b, 0);
        bus.noisy[1] = 1'b1;
        step(5);
        chk("bounce_final_pre", bus.debounced[1], 0);
        step(1);
        chk("bounce_final_rise", {bus.debounced[1], bus.p_edge[1]}, 2'b11);
        bus.noisy[1] = 1'b0;
        step(10);

        // long press on channel 2, repeat disabled
        bus.noisy[2] = 1'b1;
        lp_cnt = 0; lp_e = -1; rp_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            step(1);
            if (bus.long_press[2]) begin lp_cnt++; lp_e = k; end
            if (bus.repeat_pulse[2]) rp_cnt++;
        end
        chk("long_count", lp_cnt, 1);
        chk("long_edge", lp_e, 25);
        chk("long_no_repeat", rp_cnt, 0);
        bus.noisy[2] = 1'b0;
        ne_e = -1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (bus.n_edge[2]) ne_e = k;
        end
        chk("long_release_nedge", ne_e, 5);
        step(4);

        // auto-repeat on channel 3
        bus.repeat_en[3] = 1'b1;
        bus.noisy[3] = 1'b1;
        lp_e = -1; rq.delete();
        for (int k = 0; k < 60; k++) begin
            step(1);
            if (bus.long_press[3]) lp_e = k;
            if (bus.repeat_pulse[3]) rq.push_back(k);
        end
        chk("rep_long_edge", lp_e, 25);
        chk("rep_count", rq.size(), 6);
        chk("rep_first_gap", (rq.size() > 0) ? rq[0] - lp_e : -1, 6);
        chk("rep_span", (rq.size() > 0) ? rq[rq.size()-1] - rq[0] : -1, 25);
        bus.noisy[3] = 1'b0;
        late = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (k >= 5 && bus.repeat_pulse[3]) late++;
        end
        chk("rep_stop", late, 0);
        bus.repeat_en[3] = 1'b0;
        step(4);

        // release exactly on the long-press terminal count (channel 0)
        bus.noisy[0] = 1'b1;
        lp_cnt = 0; ne_e = -1;
        for (int k = 0; k < 35; k++) begin
            step(1);
            if (k == 19) bus.noisy[0] = 1'b0;
            if (bus.long_press[0]) lp_cnt++;
            if (bus.n_edge[0]) ne_e = k;
        end
        chk("term_no_long", lp_cnt, 0);
        chk("term_fall_edge", ne_e, 25);

        // reset mid-hold while repeating (channel 3)
        bus.repeat_en[3] = 1'b1;
        bus.noisy[3] = 1'b1;
        step(40);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_mid_zero", {8'h0, outs()}, 32'h0);
        de_e = -1; pe_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (bus.debounced[3] && de_e < 0) de_e = k;
            if (bus.p_edge[3]) pe_cnt++;
        end
        chk("rst_rerise_edge", de_e, 6);
        chk("rst_repulse_count", pe_cnt, 1);
        bus.noisy = '0;
        bus.repeat_en = '0;
        step(12);

        // randomized phase, checked cycle by cycle against the model
        nz = '0; re = '0;
        for (int seg = 0; seg < 6; seg++) begin
            for (int ch = 0; ch < N; ch++) begin
                case ($urandom_range(0, 3))
                    0: pct[ch] = 1;
                    1: pct[ch] = 2;
                    2: pct[ch] = 4;
                    default: pct[ch] = 30;
                endcase
            end
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                for (int ch = 0; ch < N; ch++) begin
                    if ($urandom_range(0, 99) < pct[ch]) nz[ch] = ~nz[ch];
                    if ($urandom_range(0, 49) == 0) re[ch] = ~re[ch];
                end
                bus.noisy = nz;
                bus.repeat_en = re;
                rst = ($urandom_range(0, 999) == 0);
            end
        end
        rst = 1'b0;
        step(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
